bus_arbiter: RTL

Two-master / three-slave arbiter and router for the serial address/data bus. It grants the bus to one requesting master, round-robin. It decodes the two leading serial address bits into a slave ID and checks that slave's readiness before letting the master continue. It then routes the master's serial lines to the selected slave, and the slave's read data back, until the master drops its request. It sits between the master instances and the slave instances at the top level.

---
 rtl/bus_arbiter_pkg.sv | 45 ++++
 rtl/bus_arbiter_rr_arbiter2.sv | 38 +++
 rtl/bus_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types, sizes and small decode helpers for the two-master / three-slave
// serial bus arbiter.
package bus_arbiter_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES  = 3;
  localparam int SID_W       = 2;

  localparam logic [SID_W-1:0] SID_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ADDR    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_ROUTE   = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  function automatic logic [NUM_SLAVES-1:0] sid_onehot(input logic [SID_W-1:0] sid);
    logic [NUM_SLAVES-1:0] oh;
    case (sid)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] mst_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic other_master(input logic idx);
    return ~idx;
  endfunction

  // The reserved ID selects nothing, so it reads back as 0.
  function automatic logic slave_bit(input logic [NUM_SLAVES-1:0] vec,
                                     input logic [SID_W-1:0] sid);
    return |(vec & sid_onehot(sid));
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the priority
// master, and priority moves to the other master when a grant is released.
module rr_arbiter2
  import bus_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       release_i,
  input  logic       owner_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic prio_q;

  // Winner selection for the current request pattern.
  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_idx_o = prio_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

  // Priority pointer; master 0 wins the first tie after reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (release_i) begin
      prio_q <= other_master(owner_i);
    end else begin
      prio_q <= prio_q;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter and router between two serial bus masters and three slaves: grants one
// master, decodes a 2-bit slave ID, waits for slave readiness, then routes lines.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 1023,
  parameter int CHK_MAX  = 255
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] m_bus_req,
  input  logic [NUM_MASTERS-1:0] m_valid_s,
  input  logic [NUM_MASTERS-1:0] m_addr_tx,
  input  logic [NUM_MASTERS-1:0] m_data_tx,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  output logic [NUM_MASTERS-1:0] m_bus_ready,
  output logic [NUM_MASTERS-1:0] m_data_rx,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_valid,
  input  logic [NUM_SLAVES-1:0]  s_data_rx,
  output logic [NUM_SLAVES-1:0]  s_valid_s,
  output logic                   s_addr_tx,
  output logic                   s_data_tx,
  output logic                   s_write_en,
  output logic                   owner,
  output logic                   busy,
  output logic                   decode_err
);

  // Release fires on the last cycle of the grant, so the ROUTE test uses LIM.
  localparam logic [9:0] HOLD_CAP = 10'(HOLD_MAX);
  localparam logic [9:0] HOLD_LIM = 10'(HOLD_MAX - 1);
  localparam logic [7:0] CHK_LIM  = 8'(CHK_MAX - 1);

  state_e                 state_q;
  logic                   owner_q;
  logic [NUM_MASTERS-1:0] bus_ready_q;
  logic                   busy_q;
  logic                   decode_err_q;
  logic [SID_W-1:0]       sid_q;
  logic                   addr_cnt_q;
  logic [7:0]             chk_cnt_q;
  logic [9:0]             grant_cnt_q;

  logic arb_valid;
  logic arb_idx;
  logic own_req;

  assign own_req = m_bus_req[owner_q];

  rr_arbiter2 u_rr (
    .clock       (clock),
    .rst_n       (rst_n),
    .req_i       (m_bus_req),
    .release_i   (state_q == ST_RELEASE),
    .owner_i     (owner_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // Transfer sequencer with registered handshake and status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      bus_ready_q  <= 2'b00;
      busy_q       <= 1'b0;
      decode_err_q <= 1'b0;
      sid_q        <= 2'b00;
      addr_cnt_q   <= 1'b0;
      chk_cnt_q    <= 8'd0;
      grant_cnt_q  <= 10'd0;
    end else begin
      decode_err_q <= 1'b0;
      if (grant_cnt_q != HOLD_CAP) begin
        grant_cnt_q <= grant_cnt_q + 10'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q     <= ST_GRANT;
            owner_q     <= arb_idx;
            bus_ready_q <= mst_onehot(arb_idx);
            busy_q      <= 1'b1;
            grant_cnt_q <= 10'd0;
          end
        end
        ST_GRANT: begin
          if (!own_req) begin
            state_q     <= ST_RELEASE;
            bus_ready_q <= 2'b00;
          end else if (m_valid_s[owner_q]) begin
            state_q     <= ST_ADDR;
            bus_ready_q <= 2'b00;
            addr_cnt_q  <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (!own_req) begin
            state_q <= ST_RELEASE;
          end else begin
            sid_q      <= {sid_q[0], m_addr_tx[owner_q]};
            addr_cnt_q <= 1'b1;
            if (addr_cnt_q) begin
              state_q   <= ST_CHECK;
              chk_cnt_q <= 8'd0;
            end
          end
        end
        ST_CHECK: begin
          if (!own_req) begin
            state_q <= ST_RELEASE;
          end else if (sid_q == SID_INVALID) begin
            state_q      <= ST_RELEASE;
            decode_err_q <= 1'b1;
          end else if (slave_bit(s_ready, sid_q)) begin
            state_q     <= ST_ROUTE;
            bus_ready_q <= mst_onehot(owner_q);
          end else if (chk_cnt_q >= CHK_LIM) begin
            state_q      <= ST_RELEASE;
            decode_err_q <= 1'b1;
          end else begin
            chk_cnt_q <= chk_cnt_q + 8'd1;
          end
        end
        ST_ROUTE: begin
          if (!own_req || (grant_cnt_q >= HOLD_LIM)) begin
            state_q     <= ST_RELEASE;
            bus_ready_q <= 2'b00;
          end
        end
        ST_RELEASE: begin
          state_q     <= ST_IDLE;
          bus_ready_q <= 2'b00;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          bus_ready_q <= 2'b00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency crossbar, live only while routing.
  always_comb begin
    s_valid_s     = 3'b000;
    s_addr_tx     = 1'b0;
    s_data_tx     = 1'b0;
    s_write_en    = 1'b0;
    m_data_rx     = 2'b00;
    m_slave_valid = 2'b00;
    if (state_q == ST_ROUTE) begin
      s_valid_s     = sid_onehot(sid_q) & {NUM_SLAVES{m_valid_s[owner_q]}};
      s_addr_tx     = m_addr_tx[owner_q];
      s_data_tx     = m_data_tx[owner_q];
      s_write_en    = m_write_en[owner_q];
      m_data_rx     = mst_onehot(owner_q) & {NUM_MASTERS{slave_bit(s_data_rx, sid_q)}};
      m_slave_valid = mst_onehot(owner_q) & {NUM_MASTERS{slave_bit(s_valid, sid_q)}};
    end else begin
      s_valid_s = 3'b000;
    end
  end

  assign m_bus_ready = bus_ready_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign decode_err  = decode_err_q;

endmodule
